// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame link: header marker, frame length,
// inter-byte timeout and the receiver state encoding.
package uart_frame_pkg;

  // Frame start marker used by both transmitter and receiver.
  localparam logic [7:0] FRAME_HDR = 8'hAA;

  // Payload bytes per frame.
  localparam int FRAME_NBYTES = 36;

  // Width and default terminal count of the inter-byte gap timer.
  localparam int GAP_W = 18;
  localparam logic [GAP_W-1:0] GAP_TIMEOUT = 18'h3FFFF;

  // Receiver states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_CHK  = 2'd2,
    ST_DONE = 2'd3
  } rx_state_t;

  // True while a frame is in flight (payload or checksum still expected).
  function automatic logic in_frame(input rx_state_t s);
    return (s == ST_RECV) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer. Counts cycles while enabled and saturates at LIMIT;
// expired is high for as long as the count sits at LIMIT. clear wins over
// enable so a byte arriving on the terminal-count cycle restarts the gap.
module uart_gap_timer
  import uart_frame_pkg::*;
#(
  parameter logic [GAP_W-1:0] LIMIT = GAP_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [GAP_W-1:0] count_reg;

  // Gap counter: cleared on demand, otherwise counts up to LIMIT and holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LIMIT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/uart_frame_rx.sv
// Frame receiver: waits for a header byte, shifts NBYTES payload bytes
// MSB-first into a wide word, optionally checks a trailing XOR checksum and
// publishes good frames with a one-cycle frame_valid pulse. Bad checksums
// and stalled frames produce a one-cycle frame_err pulse instead.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int               NBYTES   = FRAME_NBYTES,
  parameter logic [7:0]       HDR_BYTE = FRAME_HDR,
  parameter logic [GAP_W-1:0] TIMEOUT  = GAP_TIMEOUT,
  parameter int               CHK_EN   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rdsig,
  input  logic [7:0]            rxdata,
  output logic [NBYTES*8-1:0]   frame_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int W  = NBYTES * 8;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  rx_state_t      state_reg, state_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [7:0]     acc_reg, acc_next;
  logic [W-1:0]   shift_reg, shift_next;
  logic [W-1:0]   data_reg, data_next;
  logic           valid_reg, valid_next;
  logic           err_reg, err_next;

  logic           active;
  logic           gap_expired;

  assign active = in_frame(state_reg);

  // Gap timer runs only inside a frame; any accepted byte, or being outside
  // a frame, keeps it at zero.
  uart_gap_timer #(
    .LIMIT (TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (rdsig || !active),
    .enable  (active && !rdsig),
    .expired (gap_expired)
  );

  // State and datapath registers; everything returns to zero on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      acc_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      acc_reg   <= acc_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  // Next-state and datapath logic; pulses default low, data holds.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    acc_next   = acc_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        // DONE publishes the assembled frame, then behaves like IDLE for the
        // byte arriving in the same cycle so back-to-back frames work.
        if (state_reg == ST_DONE) begin
          data_next  = shift_reg;
          valid_next = 1'b1;
          state_next = ST_IDLE;
        end
        if (rdsig && (rxdata == HDR_BYTE)) begin
          state_next = ST_RECV;
          count_next = '0;
          acc_next   = '0;
        end
      end

      ST_RECV: begin
        if (rdsig) begin
          // Header-valued bytes are plain payload here; no resync.
          shift_next = {shift_reg[W-9:0], rxdata};
          acc_next   = acc_reg ^ rxdata;
          if (count_reg == LAST) begin
            count_next = '0;
            state_next = (CHK_EN != 0) ? ST_CHK : ST_DONE;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end else if (gap_expired) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end
      end

      ST_CHK: begin
        if (rdsig) begin
          if (rxdata == acc_reg) begin
            state_next = ST_DONE;
          end else begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (gap_expired) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign frame_data  = data_reg;
  assign frame_valid = valid_reg;
  assign frame_err   = err_reg;
  assign busy        = active;

endmodule
